// File: rtl/sync_fifo_lvl.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo_lvl
//  Description : Single-clock FIFO with exact fill level, almost-full/empty
//                thresholds, optional first-word-fall-through read mode and
//                sticky overflow/underflow error flags.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_lvl #(
    parameter int DSIZE    = 8,
    parameter int ASIZE    = 4,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    output logic             walmost_full,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   count,
    input  logic             err_clr,
    output logic             overflow,
    output logic             underflow
);

    localparam int             c_DEPTH_INT = 1 << ASIZE;
    localparam logic [ASIZE:0] c_DEPTH     = (ASIZE+1)'(c_DEPTH_INT);
    localparam logic [ASIZE:0] c_AF        = (ASIZE+1)'(AF_LEVEL);
    localparam logic [ASIZE:0] c_AE        = (ASIZE+1)'(AE_LEVEL);
    localparam logic [ASIZE:0] c_ONE       = {{ASIZE{1'b0}}, 1'b1};

    generate
        if (AF_LEVEL < 1 || AF_LEVEL > c_DEPTH_INT) begin : g_af_bad
            $fatal(1, "sync_fifo_lvl: AF_LEVEL out of range 1..DEPTH");
        end
        if (AE_LEVEL < 0 || AE_LEVEL > c_DEPTH_INT - 1) begin : g_ae_bad
            $fatal(1, "sync_fifo_lvl: AE_LEVEL out of range 0..DEPTH-1");
        end
    endgenerate

    logic [DSIZE-1:0] r_mem [0:c_DEPTH_INT-1];
    logic [ASIZE:0]   r_wptr;
    logic [ASIZE:0]   r_rptr;
    logic [DSIZE-1:0] r_rdata;
    logic             r_overflow;
    logic             r_underflow;

    logic [ASIZE:0]   w_mem_count;
    logic [ASIZE:0]   w_count;
    logic             w_out_valid;
    logic             w_full;
    logic             w_empty;
    logic             w_wr;
    logic             w_rd;
    logic             w_mem_rd;
    logic [ASIZE-1:0] w_waddr;
    logic [ASIZE-1:0] w_raddr;

    assign w_mem_count = r_wptr - r_rptr;
    assign w_count     = w_mem_count + {{ASIZE{1'b0}}, w_out_valid};
    assign w_full      = (w_count == c_DEPTH);
    assign w_wr        = winc && !w_full;
    assign w_rd        = rinc && !w_empty;
    assign w_waddr     = r_wptr[ASIZE-1:0];
    assign w_raddr     = r_rptr[ASIZE-1:0];

    generate
        if (FWFT != 0) begin : g_fwft
            logic r_out_valid;

            // Head register is refilled whenever it is (or is about to be) vacant.
            assign w_mem_rd    = (!r_out_valid || w_rd) && (w_mem_count != '0);
            assign w_out_valid = r_out_valid;
            assign w_empty     = !r_out_valid;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_out_valid <= 1'b0;
                end else if (w_mem_rd) begin
                    r_out_valid <= 1'b1;
                end else if (w_rd) begin
                    r_out_valid <= 1'b0;
                end
            end
        end else begin : g_std
            assign w_mem_rd    = w_rd;
            assign w_out_valid = 1'b0;
            assign w_empty     = (w_mem_count == '0);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[w_waddr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_rdata     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + c_ONE;
            end
            if (w_mem_rd) begin
                r_rptr  <= r_rptr + c_ONE;
                r_rdata <= r_mem[w_raddr];
            end
            // A new rejection takes priority over a coincident clear.
            r_overflow  <= (r_overflow  && !err_clr) || (winc && w_full);
            r_underflow <= (r_underflow && !err_clr) || (rinc && w_empty);
        end
    end

    assign count         = w_count;
    assign wfull         = w_full;
    assign walmost_full  = (w_count >= c_AF);
    assign rempty        = w_empty;
    assign ralmost_empty = (w_count <= c_AE);
    assign rdata         = r_rdata;
    assign overflow      = r_overflow;
    assign underflow     = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_lvl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sync_fifo_lvl
//  Description : Bench driving a standard-read and an FWFT instance of
//                sync_fifo_lvl from shared stimulus, each against a queue model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_lvl;

    localparam int c_DEPTH = 16;
    localparam int c_AF    = 12;
    localparam int c_AE    = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       winc = 1'b0;
    logic       rinc = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] wdata = '0;

    logic [7:0] rdata0, rdata1;
    logic [4:0] count0, count1;
    logic       wfull0, wfull1, waf0, waf1, rempty0, rempty1, rae0, rae1;
    logic       ovf0, ovf1, udf0, udf1;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sync_fifo_lvl #(.DSIZE(8), .ASIZE(4), .FWFT(0), .AF_LEVEL(c_AF), .AE_LEVEL(c_AE)) u_std (
        .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .wfull(wfull0),
        .walmost_full(waf0), .rinc(rinc), .rdata(rdata0), .rempty(rempty0),
        .ralmost_empty(rae0), .count(count0), .err_clr(err_clr),
        .overflow(ovf0), .underflow(udf0)
    );

    sync_fifo_lvl #(.DSIZE(8), .ASIZE(4), .FWFT(1), .AF_LEVEL(c_AF), .AE_LEVEL(c_AE)) u_fwft (
        .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .wfull(wfull1),
        .walmost_full(waf1), .rinc(rinc), .rdata(rdata1), .rempty(rempty1),
        .ralmost_empty(rae1), .count(count1), .err_clr(err_clr),
        .overflow(ovf1), .underflow(udf1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of words per instance.
    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] last_rd0;
    bit         vis1;
    bit         m_ovf0, m_udf0, m_ovf1, m_udf1;
    bit         mvalid = 0;

    always @(posedge clk) begin
        int  pre;
        bit  wr, rd;
        if (rst) begin
            q0.delete(); q1.delete();
            last_rd0 = 8'h00; vis1 = 0;
            m_ovf0 = 0; m_udf0 = 0; m_ovf1 = 0; m_udf1 = 0;
            mvalid = 1;
        end else if (mvalid) begin
            wr = winc && (q0.size() < c_DEPTH);
            rd = rinc && (q0.size() > 0);
            m_ovf0 = (m_ovf0 && !err_clr) || (winc && !wr);
            m_udf0 = (m_udf0 && !err_clr) || (rinc && !rd);
            if (rd) last_rd0 = q0.pop_front();
            if (wr) q0.push_back(wdata);

            // FWFT: the head becomes visible one edge after it exists at an edge.
            wr = winc && (q1.size() < c_DEPTH);
            rd = rinc && vis1;
            m_ovf1 = (m_ovf1 && !err_clr) || (winc && !wr);
            m_udf1 = (m_udf1 && !err_clr) || (rinc && !rd);
            pre = q1.size();
            if (rd) void'(q1.pop_front());
            vis1 = (pre - int'(rd)) > 0;
            if (wr) q1.push_back(wdata);
        end
    end

    always @(negedge clk) begin
        if (mvalid) begin
            check("std_count",  32'(count0),  32'(q0.size()));
            check("std_full",   32'(wfull0),  32'(q0.size() == c_DEPTH));
            check("std_afull",  32'(waf0),    32'(q0.size() >= c_AF));
            check("std_empty",  32'(rempty0), 32'(q0.size() == 0));
            check("std_aempty", 32'(rae0),    32'(q0.size() <= c_AE));
            check("std_ovf",    32'(ovf0),    32'(m_ovf0));
            check("std_udf",    32'(udf0),    32'(m_udf0));
            check("std_rdata",  32'(rdata0),  32'(last_rd0));

            check("fw_count",   32'(count1),  32'(q1.size()));
            check("fw_full",    32'(wfull1),  32'(q1.size() == c_DEPTH));
            check("fw_afull",   32'(waf1),    32'(q1.size() >= c_AF));
            check("fw_empty",   32'(rempty1), 32'(!vis1));
            check("fw_aempty",  32'(rae1),    32'(q1.size() <= c_AE));
            check("fw_ovf",     32'(ovf1),    32'(m_ovf1));
            check("fw_udf",     32'(udf1),    32'(m_udf1));
            if (vis1) check("fw_rdata", 32'(rdata1), 32'(q1[0]));
        end
    end

    task automatic step(input logic w, input logic [7:0] d, input logic r,
                        input logic c, input logic rs);
        winc = w; wdata = d; rinc = r; err_clr = c; rst = rs;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pw, pr;
        #1;
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        check("rst_count", 32'(count0), 0);
        check("rst_empty", 32'(rempty0 & rempty1), 1);
        check("rst_rdata", 32'(rdata0), 0);
        check("rst_rdata_fw", 32'(rdata1), 0);

        // Fill to full, then one rejected write.
        for (int i = 0; i < 16; i++) begin
            step(1, 8'(i), 0, 0, 0);
            if (i == 10) check("t1_af_at11", 32'(waf0), 0);
            if (i == 11) check("t1_af_at12", 32'(waf0 & waf1), 1);
        end
        check("t1_full", 32'(wfull0 & wfull1), 1);
        check("t1_count16", 32'(count1), 16);
        check("t1_fw_head", 32'(rdata1), 8'h00);
        step(1, 8'hFF, 0, 0, 0);
        check("t1_ovf", 32'(ovf0 & ovf1), 1);
        check("t1_count_kept", 32'(count0), 16);
        step(0, 0, 1, 0, 0);
        check("t1_first_rd", 32'(rdata0), 8'h00);
        check("t1_fw_next", 32'(rdata1), 8'h01);
        for (int i = 1; i < 16; i++) step(0, 0, 1, 0, 0);
        check("t1_last_rd", 32'(rdata0), 8'h0F);

        // Single word latency in both read modes, then underflow.
        step(0, 0, 0, 1, 0);
        step(1, 8'hA5, 0, 0, 0);
        check("t2_std_ready", 32'(rempty0), 0);
        check("t3_fw_notyet", 32'(rempty1), 1);
        check("t3_fw_count", 32'(count1), 1);
        step(0, 0, 0, 0, 0);
        check("t3_fw_ready", 32'(rempty1), 0);
        check("t3_fw_rdata", 32'(rdata1), 8'hA5);
        step(0, 0, 1, 0, 0);
        check("t2_std_rdata", 32'(rdata0), 8'hA5);
        check("t2_empty", 32'(rempty0 | rempty1), 1);
        check("t3_fw_count0", 32'(count1), 0);
        step(0, 0, 1, 0, 0);
        check("t2_udf", 32'(udf0 & udf1), 1);

        // Steady-state streaming across pointer wrap.
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 8'(8'h20 + i), 0, 0, 0);
        for (int i = 0; i < 40; i++) begin
            step(1, 8'(8'h25 + i), 1, 0, 0);
            if (count0 != 5 || count1 != 5) check("t4_count5", 32'({count0, count1}), {5'd5, 5'd5});
        end
        check("t4_count_end", 32'(count1), 5);
        check("t4_noerr", 32'({ovf0, udf0, ovf1, udf1}), 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0, 0);

        // Simultaneous requests at full and at empty, then clear.
        for (int i = 0; i < 16; i++) step(1, 8'(8'h60 + i), 0, 0, 0);
        step(1, 8'h77, 1, 0, 0);
        check("t5_count15", 32'(count0), 15);
        check("t5_ovf", 32'(ovf0 & ovf1), 1);
        for (int i = 0; i < 15; i++) step(0, 0, 1, 0, 0);
        step(1, 8'h88, 1, 0, 0);
        check("t5_count1", 32'(count1), 1);
        check("t5_udf", 32'(udf0 & udf1), 1);
        step(0, 0, 0, 1, 0);
        check("t5_clr", 32'({ovf0, udf0, ovf1, udf1}), 0);

        // Mid-stream reset with requests in the reset cycle.
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) step(1, 8'(8'h50 + i), 0, 0, 0);
        step(0, 0, 1, 0, 0);
        check("t6_pre", 32'(count0), 9);
        step(1, 8'h99, 1, 0, 1);
        check("t6_count", 32'(count0 | count1), 0);
        check("t6_empty", 32'(rempty0 & rempty1 & rae0 & rae1), 1);
        check("t6_rdata", 32'(rdata0 | rdata1), 0);
        check("t6_flags", 32'({wfull0, waf0, ovf0, udf0, wfull1, waf1, ovf1, udf1}), 0);

        // Randomized traffic with varying fill bias.
        pw = 50; pr = 50;
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                pw = 20 + 30 * int'($urandom_range(0, 2));
                pr = 20 + 30 * int'($urandom_range(0, 2));
            end
            step(($urandom_range(0, 99) < pw) ? 1'b1 : 1'b0, 8'($urandom),
                 ($urandom_range(0, 99) < pr) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
        end
        step(0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
